// File: rtl/popcount16_sched.sv
`default_nettype none
// ============================================================================
// Module   : popcount16_sched
// Brief    : Round-robin scheduler feeding a shared 16-bit popcount datapath,
//            with ID tag pipeline, in-flight tracking and flush/drain handshake.
// Revision : 1.0
// ============================================================================
module popcount16_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 12,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*16-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [15:0]        cnt_in,
    output logic               cnt_in_vld,
    input  logic [4:0]         cnt_res,
    output logic               rsp_vld,
    output logic [IDW-1:0]     rsp_id,
    output logic [4:0]         rsp_cnt,
    input  logic               flush,
    output logic               flush_done,
    output logic               busy,
    output logic               err
);

    localparam int CW = $clog2(LAT + 3);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_inflight;
    logic [LAT:0]     r_tag_vld;
    logic [IDW-1:0]   r_tag_id [0:LAT];

    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [IDW:0]      w_sum;
    logic              w_gnt_any;
    logic [IDW-1:0]    w_gnt_idx;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [15:0]       w_gnt_word;

    // Rotate requests so the pointer position sits at bit 0, then take the
    // lowest set bit and map its offset back to an absolute requester index.
    assign w_req2 = {req, req};
    assign w_rot  = w_req2[r_ptr +: NREQ];

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        gnt       = '0;
        if (!rst && r_state == ST_RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_gnt_any && w_rot[k]) begin
                    w_gnt_any = 1'b1;
                    w_sum     = {1'b0, r_ptr} + (IDW+1)'(k);
                    if (w_sum >= (IDW+1)'(NREQ)) begin
                        w_sum = w_sum - (IDW+1)'(NREQ);
                    end
                    w_gnt_idx = w_sum[IDW-1:0];
                end
            end
            if (w_gnt_any) begin
                gnt[w_gnt_idx] = 1'b1;
            end
        end
    end

    assign w_ptr_nxt  = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_word = req_data[{w_gnt_idx, 4'b0000} +: 16];
    assign busy       = (r_inflight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_ptr      <= '0;
            r_inflight <= '0;
            r_tag_vld  <= '0;
            cnt_in     <= '0;
            cnt_in_vld <= 1'b0;
            rsp_vld    <= 1'b0;
            rsp_id     <= '0;
            rsp_cnt    <= '0;
            flush_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            cnt_in_vld <= w_gnt_any;
            if (w_gnt_any) begin
                cnt_in <= w_gnt_word;
                r_ptr  <= w_ptr_nxt;
            end

            r_tag_vld <= {r_tag_vld[LAT-1:0], w_gnt_any};

            // The last tag stage lines up with the datapath result.
            rsp_vld <= r_tag_vld[LAT];
            if (r_tag_vld[LAT]) begin
                rsp_id  <= r_tag_id[LAT];
                rsp_cnt <= cnt_res;
                if (cnt_res > 5'd16) begin
                    err <= 1'b1;
                end
            end

            case ({w_gnt_any, rsp_vld})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            flush_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_state    <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= flush ? ST_HOLD : ST_RUN;
                end
                default: begin
                    if (!flush) begin
                        r_state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    // ID payload needs no reset: only the valid bits qualify it.
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt_idx;
        for (int s = 1; s <= LAT; s++) begin
            r_tag_id[s] <= r_tag_id[s-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_popcount16_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount16_sched
// Brief    : Self-checking bench for popcount16_sched with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_popcount16_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 12;
    localparam int IDW  = 2;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;
    localparam int M_HOLD  = 3;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*16-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [15:0]        cnt_in;
    logic               cnt_in_vld;
    logic [4:0]         cnt_res;
    logic               rsp_vld;
    logic [IDW-1:0]     rsp_id;
    logic [4:0]         rsp_cnt;
    logic               flush;
    logic               flush_done;
    logic               busy;
    logic               err;

    popcount16_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .cnt_in     (cnt_in),
        .cnt_in_vld (cnt_in_vld),
        .cnt_res    (cnt_res),
        .rsp_vld    (rsp_vld),
        .rsp_id     (rsp_id),
        .rsp_cnt    (rsp_cnt),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        int cnt;
    } rsp_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    rsp_t          q[$];
    logic [4:0]    hist[$];
    int            m_ptr;
    int            m_mode;
    bit            m_err;
    bit            m_last_vld;
    logic [15:0]   m_last_word;
    bit            inject;
    int            cyc;
    logic [NREQ-1:0] exp_gnt_last;
    int            last_rsp_cyc;
    int            last_done_cyc;
    int            first_gnt_cyc;
    int            tf;
    int            g0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: emulate the external datapath, check at negedge,
    // advance the reference model, return just after the next rising edge.
    task automatic step();
        logic [NREQ-1:0] eg;
        int   gidx;
        int   qs0;
        bit   err_nxt;
        rsp_t e;
        hist.push_front(cnt_in_vld ? 5'($countones(cnt_in)) : 5'($urandom_range(0, 31)));
        if (hist.size() > LAT + 1) void'(hist.pop_back());
        cnt_res = inject ? 5'd20 : ((hist.size() > LAT) ? hist[LAT] : 5'd0);
        @(negedge clk);
        eg      = '0;
        gidx    = -1;
        qs0     = q.size();
        err_nxt = 1'b0;
        if (!rst && m_mode == M_RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (m_ptr + k) % NREQ;
                if (gidx < 0 && req[i]) gidx = i;
            end
        end
        if (gidx >= 0) eg[gidx] = 1'b1;
        check_val("gnt", 32'(gnt), 32'(eg));
        check_val("cnt_in_vld", 32'(cnt_in_vld), 32'(m_last_vld));
        if (m_last_vld) check_val("cnt_in", 32'(cnt_in), 32'(m_last_word));
        if (q.size() > 0 && q[0].due == cyc) begin
            check_val("rsp_vld", 32'(rsp_vld), 32'd1);
            check_val("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check_val("rsp_cnt", 32'(rsp_cnt), 32'(q[0].cnt));
            void'(q.pop_front());
        end else begin
            check_val("rsp_vld", 32'(rsp_vld), 32'd0);
        end
        if (inject && q.size() > 0 && q[0].due == cyc + 1) begin
            q[0].cnt = 20;
            err_nxt  = 1'b1;
        end
        check_val("busy", 32'(busy), 32'(qs0 != 0));
        check_val("err", 32'(err), 32'(m_err));
        check_val("flush_done", 32'(flush_done), 32'(m_mode == M_DONE));
        if (rsp_vld === 1'b1) last_rsp_cyc = cyc;
        if (flush_done === 1'b1) last_done_cyc = cyc;
        if (gnt !== '0 && first_gnt_cyc < 0) first_gnt_cyc = cyc;

        if (gidx >= 0) begin
            e.due = cyc + LAT + 2;
            e.id  = gidx;
            e.cnt = $countones(req_data[16*gidx +: 16]);
            q.push_back(e);
            m_ptr       = (gidx + 1) % NREQ;
            m_last_word = req_data[16*gidx +: 16];
        end
        m_last_vld = (gidx >= 0);
        case (m_mode)
            M_RUN:   if (flush) m_mode = M_DRAIN;
            M_DRAIN: if (qs0 == 0) m_mode = M_DONE;
            M_DONE:  m_mode = flush ? M_HOLD : M_RUN;
            default: if (!flush) m_mode = M_RUN;
        endcase
        m_err        = m_err | err_nxt;
        exp_gnt_last = eg;
        if (rst) begin
            q.delete();
            m_ptr       = 0;
            m_mode      = M_RUN;
            m_err       = 1'b0;
            m_last_vld  = 1'b0;
            m_last_word = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_random(input int n, input int flush_pct);
        exp_gnt_last = '0;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_gnt_last[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[16*i +: 16] = 16'($urandom);
                end
            end
            if (int'($urandom_range(0, 99)) < flush_pct) flush = ~flush;
            step();
        end
        req   = '0;
        flush = 1'b0;
        repeat (LAT + 6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0; flush = 1'b0; cnt_res = '0; inject = 1'b0;
        m_ptr = 0; m_mode = M_RUN; m_err = 1'b0; m_last_vld = 1'b0; m_last_word = '0;
        cyc = 0; exp_gnt_last = '0;
        last_rsp_cyc = -1; last_done_cyc = -1; first_gnt_cyc = -1;
        @(posedge clk);
        #1;
        step();
        step();
        check_val("rst_cnt_in", 32'(cnt_in), 32'd0);
        check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_val("rst_rsp_cnt", 32'(rsp_cnt), 32'd0);
        rst = 1'b0;

        // Single word, full count
        req = 4'b0001;
        req_data[15:0] = 16'hFFFF;
        g0 = cyc;
        step();
        req = '0;
        repeat (16) step();
        check_val("single_latency", 32'(last_rsp_cyc - g0), 32'd14);

        // Round-robin over all four with counts 4, 8, 12, 16
        for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = 16'((32'd1 << (4*(i+1))) - 1);
        req = 4'b1111;
        repeat (8) step();
        req = '0;
        repeat (16) step();

        // Fairness between two requesters, with an idle gap
        req_data = {16'h1234, 16'h00F0, 16'h8001, 16'h0003};
        req = 4'b0101;
        repeat (6) step();
        req = '0;
        step();
        req = 4'b0101;
        repeat (4) step();
        req = '0;
        repeat (16) step();

        run_random(200, 0);

        // Flush while streaming
        for (int i = 0; i < NREQ; i++) req_data[16*i +: 16] = 16'($urandom);
        req = 4'b1111;
        repeat (10) step();
        flush = 1'b1;
        tf = cyc;
        last_done_cyc = -1;
        repeat (20) step();
        flush = 1'b0;
        first_gnt_cyc = -1;
        repeat (4) step();
        req = '0;
        repeat (LAT + 4) step();
        check_val("flush_done_time", 32'(last_done_cyc - tf), 32'd15);
        check_val("restart_time", 32'(first_gnt_cyc - tf), 32'd21);

        // Flush with nothing in flight
        flush = 1'b1;
        tf = cyc;
        last_done_cyc = -1;
        repeat (4) step();
        flush = 1'b0;
        repeat (3) step();
        check_val("idle_flush_time", 32'(last_done_cyc - tf), 32'd2);

        // Reset with words outstanding
        req = 4'b1111;
        repeat (5) step();
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_rsp_cyc = -1;
        repeat (LAT + 2) step();
        check_val("rst_drops_rsp", 32'(last_rsp_cyc), 32'hFFFF_FFFF);
        req = 4'b1111;
        step();
        req = '0;
        repeat (LAT + 4) step();

        // Out-of-range result without a tag, then with a tag
        inject = 1'b1;
        step();
        inject = 1'b0;
        repeat (2) step();
        check_val("err_untagged", 32'(err), 32'd0);
        req = 4'b0010;
        req_data[31:16] = 16'h0F0F;
        g0 = cyc;
        step();
        req = '0;
        while (cyc < g0 + 1 + LAT) step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        repeat (5) step();
        check_val("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        run_random(300, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
